// File: rtl/fsm_seg_display_if.sv
// fsm_seg_display_if: display-stage control inputs and registered display outputs
interface fsm_seg_display_if;
  logic       ena;
  logic [1:0] state_in;
  logic       done_in;
  logic       clr_runs;
  logic [7:0] seg_out;
  logic [3:0] run_count;
  logic       overflow;
  modport master(output ena, state_in, done_in, clr_runs, input seg_out, run_count, overflow);
  modport slave(input ena, state_in, done_in, clr_runs, output seg_out, run_count, overflow);
endinterface

// File: rtl/fsm_seg_display.sv
// fsm_seg_display: 7-segment run counter with blinking dp, completion flash and sticky error glyph
module fsm_seg_display #(
  parameter logic [23:0] BLINK_DIV   = 24'd10_000_000,
  parameter logic [7:0]  HOLD_CYCLES = 8'd4
) (
  input logic               clk,
  input logic               rst_n,
  fsm_seg_display_if.slave  bus
);
  localparam logic [111:0] GLYPHS = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                     7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  logic        done_prev, err, flash, blink_ph;
  logic [7:0]  hold;
  logic [23:0] blink_cnt;
  logic        ev, err_n, flash_n, counting, blink_wrap;
  logic [3:0]  cnt_n;
  logic [6:0]  hex;
  // a clear discards a coincident done edge, so ev already excludes it
  always_comb begin
    ev         = bus.done_in & ~done_prev & ~bus.clr_runs;
    counting   = bus.ena & (bus.state_in == 2'b01);
    blink_wrap = blink_cnt == BLINK_DIV - 24'd1;
    cnt_n      = bus.clr_runs ? 4'd0 : ev ? bus.run_count + 4'd1 : bus.run_count;
    err_n      = bus.clr_runs ? 1'b0 : err | (bus.state_in == 2'b11);
    flash_n    = ev | (flash & (hold != 8'd0));
    hex        = GLYPHS[7'(cnt_n) * 7'd7 +: 7];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_prev     <= 1'b0;
      err           <= 1'b0;
      flash         <= 1'b0;
      hold          <= 8'd0;
      blink_cnt     <= 24'd0;
      blink_ph      <= 1'b1;
      bus.run_count <= 4'd0;
      bus.overflow  <= 1'b0;
      bus.seg_out   <= 8'h00;
    end else begin
      done_prev <= bus.done_in;
      if (bus.ena) begin
        bus.run_count <= cnt_n;
        bus.overflow  <= bus.clr_runs ? 1'b0 : bus.overflow | (ev & (bus.run_count == 4'hF));
        err           <= err_n;
        flash         <= flash_n;
        hold          <= ev ? HOLD_CYCLES - 8'd1 : (hold != 8'd0) ? hold - 8'd1 : 8'd0;
        blink_cnt     <= (!counting || blink_wrap) ? 24'd0 : blink_cnt + 24'd1;
        blink_ph      <= !counting ? 1'b1 : blink_wrap ? ~blink_ph : blink_ph;
      end
      bus.seg_out <= !bus.ena ? 8'h00 : (!bus.clr_runs && (err | (bus.state_in == 2'b11))) ? 8'hF9 :
                     flash_n ? 8'hFF : {counting & blink_ph, hex};
    end
  end
endmodule

// File: tb/tb_fsm_seg_display.sv
// tb_fsm_seg_display: directed checks of counting, flash, blink, error, clear and enable freeze
module tb_fsm_seg_display;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  fsm_seg_display_if bus();
  fsm_seg_display #(.BLINK_DIV(24'd3), .HOLD_CYCLES(8'd4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.ena = 1'b1; bus.state_in = 2'b00; bus.done_in = 1'b0; bus.clr_runs = 1'b0;
    step();
    tests++; if (bus.seg_out !== 8'h00) begin fails++; $display("FAIL reset_seg got=%h exp=00", bus.seg_out); end
    tests++; if (bus.run_count !== 4'd0) begin fails++; $display("FAIL reset_cnt got=%0d exp=0", bus.run_count); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
    rst_n = 1'b1;
    step();
    tests++; if (bus.seg_out !== 8'h3F) begin fails++; $display("FAIL idle_seg got=%h exp=3F", bus.seg_out); end
  endtask

  task automatic test_single_done();
    bus.done_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.done_in = 1'b0;
      step();
      tests++; if (bus.seg_out !== 8'hFF) begin fails++; $display("FAIL flash_seg[%0d] got=%h exp=FF", i, bus.seg_out); end
      tests++; if (bus.run_count !== 4'd1) begin fails++; $display("FAIL held_cnt[%0d] got=%0d exp=1", i, bus.run_count); end
    end
    step();
    tests++; if (bus.seg_out !== 8'h06) begin fails++; $display("FAIL after_flash got=%h exp=06", bus.seg_out); end
  endtask

  task automatic test_blink();
    bus.done_in = 1'b1; step(); bus.done_in = 1'b0;
    for (int i = 0; i < 4; i++) step();
    tests++; if (bus.seg_out !== 8'h5B) begin fails++; $display("FAIL pre_blink got=%h exp=5B", bus.seg_out); end
    bus.state_in = 2'b01;
    for (int i = 0; i < 12; i++) begin
      step();
      tests++;
      if (bus.seg_out !== (((i / 3) % 2 == 0) ? 8'hDB : 8'h5B)) begin
        fails++; $display("FAIL blink[%0d] got=%h exp=%h", i, bus.seg_out, ((i / 3) % 2 == 0) ? 8'hDB : 8'h5B);
      end
    end
    bus.state_in = 2'b00;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++; if (bus.seg_out !== 8'h5B) begin fails++; $display("FAIL leave_count[%0d] got=%h exp=5B", i, bus.seg_out); end
    end
  endtask

  task automatic test_wrap_clear();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bus.done_in = 1'b1; step(); bus.done_in = 1'b0; step();
    end
    tests++; if (bus.run_count !== 4'd15) begin fails++; $display("FAIL cnt15 got=%0d exp=15", bus.run_count); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL ovf_early got=%b exp=0", bus.overflow); end
    bus.done_in = 1'b1; step(); bus.done_in = 1'b0;
    tests++; if (bus.run_count !== 4'd0) begin fails++; $display("FAIL wrap_cnt got=%0d exp=0", bus.run_count); end
    tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL wrap_ovf got=%b exp=1", bus.overflow); end
    for (int i = 0; i < 4; i++) step();
    tests++; if (bus.seg_out !== 8'h3F) begin fails++; $display("FAIL wrap_seg got=%h exp=3F", bus.seg_out); end
    bus.clr_runs = 1'b1; bus.done_in = 1'b1; step();
    tests++; if (bus.run_count !== 4'd0) begin fails++; $display("FAIL clr_cnt got=%0d exp=0", bus.run_count); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL clr_ovf got=%b exp=0", bus.overflow); end
    tests++; if (bus.seg_out !== 8'h3F) begin fails++; $display("FAIL clr_noflash got=%h exp=3F", bus.seg_out); end
    bus.clr_runs = 1'b0; bus.done_in = 1'b0; step();
  endtask

  task automatic test_error();
    bus.state_in = 2'b11; step();
    tests++; if (bus.seg_out !== 8'hF9) begin fails++; $display("FAIL err_set got=%h exp=F9", bus.seg_out); end
    bus.state_in = 2'b00; step();
    tests++; if (bus.seg_out !== 8'hF9) begin fails++; $display("FAIL err_sticky got=%h exp=F9", bus.seg_out); end
    bus.done_in = 1'b1; step(); bus.done_in = 1'b0;
    tests++; if (bus.run_count !== 4'd1) begin fails++; $display("FAIL err_cnt got=%0d exp=1", bus.run_count); end
    tests++; if (bus.seg_out !== 8'hF9) begin fails++; $display("FAIL err_over_flash got=%h exp=F9", bus.seg_out); end
    for (int i = 0; i < 4; i++) step();
    bus.clr_runs = 1'b1; step(); bus.clr_runs = 1'b0;
    tests++; if (bus.seg_out !== 8'h3F) begin fails++; $display("FAIL err_clr got=%h exp=3F", bus.seg_out); end
    tests++; if (bus.run_count !== 4'd0) begin fails++; $display("FAIL err_clr_cnt got=%0d exp=0", bus.run_count); end
  endtask

  task automatic test_ena_freeze();
    bus.done_in = 1'b1; step(); bus.done_in = 1'b0; step();
    bus.ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.done_in = (i == 1);
      step();
      tests++; if (bus.seg_out !== 8'h00) begin fails++; $display("FAIL ena_blank[%0d] got=%h exp=00", i, bus.seg_out); end
    end
    tests++; if (bus.run_count !== 4'd1) begin fails++; $display("FAIL ena_cnt got=%0d exp=1", bus.run_count); end
    bus.ena = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (bus.seg_out !== ((i < 2) ? 8'hFF : 8'h06)) begin
        fails++; $display("FAIL ena_resume[%0d] got=%h exp=%h", i, bus.seg_out, (i < 2) ? 8'hFF : 8'h06);
      end
    end
  endtask

  task automatic test_back_to_back();
    bus.done_in = 1'b1; step(); bus.done_in = 1'b0; step();
    bus.done_in = 1'b1; step(); bus.done_in = 1'b0;
    tests++; if (bus.run_count !== 4'd3) begin fails++; $display("FAIL b2b_cnt got=%0d exp=3", bus.run_count); end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (bus.seg_out !== 8'hFF) begin fails++; $display("FAIL b2b_flash[%0d] got=%h exp=FF", i, bus.seg_out); end
    end
    step();
    tests++; if (bus.seg_out !== 8'h4F) begin fails++; $display("FAIL b2b_digit got=%h exp=4F", bus.seg_out); end
  endtask

  task automatic test_reset_mid();
    bus.done_in = 1'b1; step(); bus.done_in = 1'b0;
    rst_n = 1'b0; step();
    tests++; if (bus.seg_out !== 8'h00) begin fails++; $display("FAIL mid_rst_seg got=%h exp=00", bus.seg_out); end
    tests++; if (bus.run_count !== 4'd0) begin fails++; $display("FAIL mid_rst_cnt got=%0d exp=0", bus.run_count); end
    rst_n = 1'b1; step();
    tests++; if (bus.seg_out !== 8'h3F) begin fails++; $display("FAIL mid_rst_resume got=%h exp=3F", bus.seg_out); end
  endtask

  initial begin
    test_reset();
    test_single_done();
    test_blink();
    test_wrap_clear();
    test_error();
    test_ena_freeze();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fsm_seg_display.md
# fsm_seg_display

Downstream display stage for the start/count/reset sequencing FSM. It consumes the FSM's 2-bit state code and its `done` pulse, and keeps a count of completed runs. It drives the 7-segment display with a hex digit of that count, a blinking decimal point while counting, a full-segment flash on completion, and a sticky error glyph on an illegal state code.

## Interface
Parameters:
- `BLINK_DIV`, 24'd10_000_000, clock cycles per decimal-point blink half-period; legal range ≥2.
- `HOLD_CYCLES`, 8'd4, cycles the completion flash is held; legal range ≥1.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, **synchronous, active-low**.
- `ena`  in  1  enable; low blanks the display and freezes internal state.
- `state_in`  in  2  FSM state code: 00 IDLE, 01 COUNT, 10 RESET, 11 illegal.
- `done_in`  in  1  FSM completion flag; only rising edges are counted.
- `clr_runs`  in  1  synchronous clear of the run count, overflow flag and error flag.
- `seg_out`  out  8  registered; bit7 = dp, bits6:0 = g..a, active-high.
- `run_count`  out  4  registered count of completed runs, modulo 16.
- `overflow`  out  1  registered sticky flag; set when `run_count` wraps 15→0.

## Operation
- **Reset** (`rst_n`=0 at a clock edge) takes effect at that edge:
  - `seg_out`=0x00, `run_count`=0, `overflow`=0.
  - Error flag=0, hold counter=0, blink counter=0, blink phase=1, `done_prev`=0.
- **Edge detect**
  - `done_prev` samples `done_in` every cycle, regardless of `ena`.
  - `done_rise` = `done_in` & !`done_prev`.
  - A `done_in` held high counts once.
- **Run counter** (updates only when `ena`=1)
  - `done_rise` → `run_count`+1 mod 16.
  - On the 15→0 wrap, `overflow` is set.
  - `clr_runs`=1 → `run_count`=0, `overflow`=0, error flag=0. This beats a simultaneous `done_rise`: the edge is discarded.
- **Error flag**
  - Set when `ena`=1 and `state_in`=11.
  - Sticky until `clr_runs` or reset.
  - Setting beats clearing in the same cycle only if `clr_runs`=0.
- **Flash**
  - `done_rise` (with `ena`=1) loads the hold counter with `HOLD_CYCLES`-1 and enters flash.
  - Flash ends when the hold counter reaches 0 at an edge.
  - A new `done_rise` during flash reloads the counter (restart).
- **Blink** (only while `ena`=1 and `state_in`=01)
  - The blink counter counts 0..`BLINK_DIV`-1.
  - On the wrap to 0, blink phase toggles.
  - In any other state code: blink counter=0, blink phase=1. Entering COUNT therefore always starts with dp on.
- **Display select**, highest priority first. `hex` is the glyph of the next-state `run_count`:
  1. `ena`=0 → 0x00.
  2. Error flag (next value) → 0xF9 ("E" with dp).
  3. Flash (next value) → 0xFF.
  4. `state_in`=01 → {blink phase, `hex`}.
  5. Otherwise → {0, `hex`}.
- **Hex glyphs** (g..a), digits 0–F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- **`ena`=0 behaviour**
  - Every register except `done_prev` holds.
  - `seg_out` goes to 0x00 at the next edge.
  - `done_rise` events seen while `ena`=0 are lost.

## Timing
- All outputs are registered; the latency from any input to its effect on outputs is 1 edge.
- **Flash window**
  - `done_rise` sampled at edge N: `run_count` updates and `seg_out`=0xFF at edge N.
  - The flash holds through edge N+`HOLD_CYCLES`-1.
  - The digit of the new count shows at edge N+`HOLD_CYCLES`, if no other event intervenes.
- **Blink period**
  - dp high for `BLINK_DIV` cycles, then low for `BLINK_DIV` cycles, measured from COUNT entry.
  - `ena`=0 pauses the phase; it does not reset it.
- **Reset mid-operation**: reset at any edge aborts flash, blink and error. At the next edge with `rst_n`=1, normal selection resumes from the reset values.

## Test plan
1. **Reset, then idle display.** Assert reset, then `ena`=1, `state_in`=00 → `seg_out`=0x00 during reset, then 0x3F; `run_count`=0; `overflow`=0.
2. **Single completion with `done_in` held.** `done_in` held high 3 cycles at edge N, `HOLD_CYCLES`=4 → `run_count`=1 at edge N; `seg_out`=0xFF for edges N..N+3; 0x06 at N+4; count does not increment again.
3. **Blink in COUNT.** `BLINK_DIV`=3, `state_in`=01, `run_count`=2 → `seg_out` alternates 0xDB ×3 cycles, then 0x5B ×3 cycles, repeating; leaving COUNT gives 0x5B steady.
4. **Wrap and clear.**
   - 16 `done_in` pulses → `run_count`=0, `overflow`=1.
   - `clr_runs` coincident with a 17th pulse → `run_count`=0, `overflow`=0, and no flash.
5. **Illegal state is sticky.** `state_in`=11 for 1 cycle, then 00 → `seg_out`=0xF9 persists; a `done_rise` increments `run_count` but `seg_out` stays 0xF9; `clr_runs` restores the hex digit.
6. **`ena` freeze.** `ena`=0 during flash → `seg_out`=0x00, hold counter frozen, `done_in` edges ignored; `ena`=1 → flash resumes for its remaining cycles.
